// File: rtl/as2650_io_responder.sv
// -----------------------------------------------------------------------------
// as2650_io_responder
//
// Extended-I/O slave for a 2650-style bus. It decodes an extended I/O cycle
// (opreq=1, m_io=0, d_c=1, adr[7:2]==PORT_BASE[7:2]), inserts WAIT wait
// cycles, pulses opack for one cycle and keeps read data on the bus until the
// CPU drops opreq. Four registers sit behind the port:
//   0 : gpio_out latch (R/W)
//   1 : synchronised gpio_in (R)
//   2 : timer reload/count (W loads both, R returns the live count)
//   3 : timer control/status {flag, 6'b0, en} (bit0 = en, bit7 = W1C flag)
//
// Ports
//   clk       : clock, all state on the rising edge
//   reset_n   : asynchronous active-low reset
//   adr       : CPU address bus, adr[1:0] selects the register
//   dbus_in   : CPU write data
//   dbus_out  : read data towards the CPU
//   dbus_oe   : high while a read result is being driven (ACK and HOLD)
//   opreq     : operation request
//   m_io      : 1 = memory cycle, 0 = I/O cycle
//   d_c       : 1 = extended/data I/O, 0 = control I/O
//   rw        : 1 = write, 0 = read
//   opack     : one-cycle acknowledge
//   gpio_in   : asynchronous input port
//   gpio_out  : latched output port
//   irq       : timer flag (level)
// -----------------------------------------------------------------------------
module as2650_io_responder #(
  parameter logic [7:0]  PORT_BASE = 8'hF0,
  parameter int unsigned WAIT      = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [12:0] adr,
  input  logic [7:0]  dbus_in,
  output logic [7:0]  dbus_out,
  output logic        dbus_oe,
  input  logic        opreq,
  input  logic        m_io,
  input  logic        d_c,
  input  logic        rw,
  output logic        opack,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  // The wait counter is loaded with WAIT-1 on leaving IDLE so that exactly
  // WAIT cycles are spent in S_WAIT.
  localparam int unsigned WAIT_M1   = (WAIT == 0) ? 0 : WAIT - 1;
  localparam logic [3:0]  WAIT_INIT = WAIT_M1[3:0];

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        rw_q, rw_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  gpio_q, gpio_d;
  logic [7:0]  reload_q, reload_d;
  logic [7:0]  count_q, count_d;
  logic        en_q, en_d;
  logic        flag_q, flag_d;
  logic [7:0]  sync1_q, sync2_q;

  logic        sel;
  logic        wr_en;
  logic        expire;
  logic        unused_adr;

  // Upper address bits take no part in the extended-I/O decode.
  assign unused_adr = ^adr[12:8];

  assign sel = opreq & ~m_io & d_c & (adr[7:2] == PORT_BASE[7:2]);

  // ---------------------------------------------------------------------------
  // Bus FSM: next state, captured register index / direction, read data
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (sel) begin
          idx_d = adr[1:0];
          rw_d  = rw;
          if (WAIT == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        // An abandoned request wins over the final wait cycle.
        if (!opreq) begin
          state_d = S_IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!opreq) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read data is sampled on the edge that enters ACK; idx_d already holds
    // the index captured on the IDLE exit (even when WAIT is zero).
    if ((state_q != S_ACK) && (state_d == S_ACK)) begin
      case (idx_d)
        2'd0:    rdata_d = gpio_q;
        2'd1:    rdata_d = sync2_q;
        2'd2:    rdata_d = count_q;
        default: rdata_d = {flag_q, 6'b000000, en_q};
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register file and timer
  // ---------------------------------------------------------------------------
  assign wr_en  = (state_q == S_ACK) & rw_q;
  assign expire = en_q & (count_q == 8'd0);

  always_comb begin
    gpio_d   = gpio_q;
    reload_d = reload_q;
    count_d  = count_q;
    en_d     = en_q;
    flag_d   = flag_q;

    if (en_q) begin
      count_d = expire ? reload_q : (count_q - 8'd1);
    end

    // A register-2 write overrides the running count, including a reload.
    if (wr_en) begin
      case (idx_q)
        2'd0: gpio_d = dbus_in;
        2'd2: begin
          reload_d = dbus_in;
          count_d  = dbus_in;
        end
        2'd3: begin
          en_d = dbus_in[0];
          if (dbus_in[7]) begin
            flag_d = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end

    // Expiry set takes precedence over a coincident W1C clear.
    if (expire) begin
      flag_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wcnt_q   <= 4'd0;
      idx_q    <= 2'd0;
      rw_q     <= 1'b0;
      rdata_q  <= 8'h00;
      gpio_q   <= 8'h00;
      reload_q <= 8'h00;
      count_q  <= 8'h00;
      en_q     <= 1'b0;
      flag_q   <= 1'b0;
      sync1_q  <= 8'h00;
      sync2_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      idx_q    <= idx_d;
      rw_q     <= rw_d;
      rdata_q  <= rdata_d;
      gpio_q   <= gpio_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      en_q     <= en_d;
      flag_q   <= flag_d;
      sync1_q  <= gpio_in;
      sync2_q  <= sync1_q;
    end
  end

  assign opack    = (state_q == S_ACK);
  assign dbus_oe  = ((state_q == S_ACK) || (state_q == S_HOLD)) & ~rw_q;
  assign dbus_out = rdata_q;
  assign gpio_out = gpio_q;
  assign irq      = flag_q;

endmodule

// File: tb/tb_as2650_io_responder.sv
module tb_as2650_io_responder;

  localparam int         WAIT_T = 3;
  localparam logic [7:0] BASE   = 8'hF0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] adr;
  logic [7:0]  dbus_in;
  logic [7:0]  dbus_out;
  logic        dbus_oe;
  logic        opreq;
  logic        m_io;
  logic        d_c;
  logic        rw;
  logic        opack;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        irq;

  as2650_io_responder #(.PORT_BASE(BASE), .WAIT(WAIT_T)) dut (
    .clk(clk), .reset_n(reset_n), .adr(adr), .dbus_in(dbus_in),
    .dbus_out(dbus_out), .dbus_oe(dbus_oe), .opreq(opreq), .m_io(m_io),
    .d_c(d_c), .rw(rw), .opack(opack), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. The timer is described in closed form from a base edge:
  // after edge m_b the count is m_C, reload m_R, enable m_en, flag m_flag.
  // ---------------------------------------------------------------------------
  int         m_b = 0;
  int         m_C = 0;
  int         m_R = 0;
  bit         m_en = 0;
  bit         m_flag = 0;
  logic [7:0] m_gpo = 8'h00;
  logic [7:0] m_gpi = 8'h00;

  function automatic int count_at(input int e);
    int k;
    if (!m_en) return m_C;
    k = e - m_b;
    if (k <= m_C) return m_C - k;
    return m_R - ((k - m_C - 1) % (m_R + 1));
  endfunction

  // First expiry after the base edge happens on edge m_b + m_C + 1.
  function automatic bit flag_at(input int e);
    return m_flag | (m_en && ((e - m_b) >= (m_C + 1)));
  endfunction

  function automatic logic [7:0] exp_read(input logic [1:0] r, input int e);
    case (r)
      2'd0:    return m_gpo;
      2'd1:    return m_gpi;
      2'd2:    return 8'(count_at(e));
      default: return {flag_at(e), 6'b000000, m_en};
    endcase
  endfunction

  task automatic model_commit(input int w, input logic [1:0] r, input logic [7:0] d);
    bit expw;
    bit fl;
    int nc;
    expw = m_en && (count_at(w - 1) == 0);
    fl   = flag_at(w - 1) | expw;
    if (r == 2'd3 && d[7] && !expw) fl = 0;
    nc = (r == 2'd2) ? int'(d) : count_at(w);
    if (r == 2'd0) m_gpo = d;
    if (r == 2'd2) m_R = int'(d);
    if (r == 2'd3) m_en = d[0];
    m_b = w; m_C = nc; m_flag = fl;
  endtask

  task automatic model_reset();
    m_b = cyc; m_C = 0; m_R = 0; m_en = 0; m_flag = 0; m_gpo = 8'h00;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard and monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    int         ack_cyc;
    bit         rd;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];

  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      check("irq_level", irq, flag_at(cyc));
      check("gpio_out", gpio_out, m_gpo);
      if (opack === 1'b1) begin
        if (sbq.size() == 0) begin
          check("spurious_opack", opack, 1'b0);
        end else begin
          e = sbq.pop_front();
          check("ack_cycle", cyc, e.ack_cyc);
          check("ack_oe", dbus_oe, e.rd);
          if (e.rd) check("ack_rdata", dbus_out, e.data);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks. Each starts and ends 1 time unit after a rising edge.
  // kind: 0 = complete, 1 = abort during WAIT, 2 = reset during ACK.
  // ---------------------------------------------------------------------------
  task automatic gap(input int n, input bit chg);
    opreq = 1'b0;
    m_io  = 1'($urandom);
    d_c   = 1'($urandom);
    adr   = 13'($urandom);
    rw    = 1'($urandom);
    if (chg) begin
      gpio_in = 8'($urandom);
      m_gpi   = gpio_in;
    end
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_txn(input logic [12:0] a, input bit w, input logic [7:0] d,
                         input int kind, input int hold);
    int s;
    int h;
    logic [7:0] ev;
    exp_t it;
    s  = cyc;
    ev = exp_read(a[1:0], s + WAIT_T);
    adr = a; rw = w; dbus_in = d; m_io = 1'b0; d_c = 1'b1; opreq = 1'b1;
    if (kind == 0) begin
      it.ack_cyc = s + 1 + WAIT_T;
      it.rd      = !w;
      it.data    = ev;
      sbq.push_back(it);
    end
    @(posedge clk); #1;
    // Disturb the captured fields once the selection has been taken.
    adr[1:0] = 2'($urandom);
    rw       = 1'($urandom);
    if (kind == 1) begin
      repeat ($urandom_range(0, WAIT_T - 1)) begin @(posedge clk); #1; end
      opreq = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      return;
    end
    repeat (WAIT_T) begin @(posedge clk); #1; end
    if (kind == 2) begin
      reset_n = 1'b0;
      model_reset();
      #1;
      check("rst_opack", opack, 1'b0);
      check("rst_dbus_oe", dbus_oe, 1'b0);
      check("rst_dbus_out", dbus_out, 8'h00);
      check("rst_gpio_out", gpio_out, 8'h00);
      check("rst_irq", irq, 1'b0);
      @(posedge clk); #1;
      opreq = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      return;
    end
    @(posedge clk); #1;
    if (w) model_commit(cyc, a[1:0], d);
    h = (hold < 0) ? int'($urandom_range(0, 2)) : hold;
    repeat (h) begin @(posedge clk); #1; end
    opreq = 1'b0;
    @(negedge clk);
    check("hold_oe", dbus_oe, !w);
    if (!w) check("hold_rdata", dbus_out, ev);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_oe", dbus_oe, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic non_select(input int variant);
    adr     = {5'($urandom), BASE[7:2], 2'($urandom)};
    rw      = 1'($urandom);
    dbus_in = 8'($urandom);
    m_io    = 1'b0;
    d_c     = 1'b1;
    case (variant)
      0: m_io = 1'b1;
      1: d_c = 1'b0;
      2: adr = 13'h0E0;
      default: adr[7:2] = BASE[7:2] ^ 6'($urandom_range(1, 63));
    endcase
    opreq = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("nosel_opack", opack, 1'b0);
      check("nosel_oe", dbus_oe, 1'b0);
      @(posedge clk); #1;
    end
    opreq = 1'b0;
  endtask

  task automatic random_txn();
    int k;
    logic [1:0] r;
    logic [7:0] d;
    k = $urandom_range(0, 9);
    r = 2'($urandom);
    d = 8'($urandom);
    if (k <= 5) begin
      run_txn({5'($urandom), BASE[7:2], r}, 1'($urandom), d, 0, -1);
    end else if (k == 6) begin
      non_select($urandom_range(0, 3));
    end else if (k == 7) begin
      run_txn({5'($urandom), BASE[7:2], r}, 1'b1, d, 1, -1);
    end else if (k == 8) begin
      run_txn({5'($urandom), BASE[7:2], 2'd2}, 1'b1, 8'($urandom_range(0, 6)), 0, -1);
    end else begin
      run_txn({5'($urandom), BASE[7:2], 2'd3}, 1'b1, d, 0, -1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset_n = 1'b0; opreq = 1'b0; m_io = 1'b0; d_c = 1'b0; rw = 1'b0;
    adr = 13'h0; dbus_in = 8'h00; gpio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("init_opack", opack, 1'b0);
    check("init_dbus_oe", dbus_oe, 1'b0);
    check("init_dbus_out", dbus_out, 8'h00);
    check("init_gpio_out", gpio_out, 8'h00);
    check("init_irq", irq, 1'b0);
    model_reset();
    reset_n = 1'b1;
    gap(3, 1'b0);

    // Register 0 write, then read back.
    run_txn(13'h0F0, 1'b1, 8'hA5, 0, -1);
    gap(3, 1'b0);
    run_txn(13'h0F0, 1'b0, 8'h00, 0, -1);

    // Register 1 read of a held input; writes to it are ignored.
    gpio_in = 8'h3C; m_gpi = 8'h3C;
    gap(3, 1'b0);
    run_txn(13'h0F1, 1'b0, 8'h00, 0, -1);
    gap(3, 1'b0);
    run_txn(13'h0F1, 1'b1, 8'hFF, 0, -1);
    gap(3, 1'b0);

    // Non-selection.
    non_select(0);
    gap(2, 1'b0);
    non_select(2);
    gap(2, 1'b0);

    // Timer: reload 3, enable, flag four cycles later.
    run_txn(13'h0F2, 1'b1, 8'h03, 0, -1);
    gap(2, 1'b0);
    run_txn(13'h0F3, 1'b1, 8'h01, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("timer_before_expiry", irq, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("timer_expiry", irq, 1'b1);
    @(posedge clk); #1;

    // W1C away from an expiry clears the flag.
    for (int i = 0; i < 16 && count_at(cyc + 1 + WAIT_T) != 3; i++) begin
      @(posedge clk); #1;
    end
    run_txn(13'h0F3, 1'b1, 8'h81, 0, 0);
    @(negedge clk);
    check("w1c_clear", irq, 1'b0);
    @(posedge clk); #1;

    // W1C on the expiry edge: set wins.
    for (int i = 0; i < 16 && count_at(cyc + 1 + WAIT_T) != 0; i++) begin
      @(posedge clk); #1;
    end
    run_txn(13'h0F3, 1'b1, 8'h81, 0, 0);
    @(negedge clk);
    check("w1c_vs_set", irq, 1'b1);
    @(posedge clk); #1;

    // Zero reload (expires every cycle), then a register-2 write over it.
    run_txn(13'h0F2, 1'b1, 8'h00, 0, -1);
    gap(2, 1'b0);
    run_txn(13'h0F3, 1'b1, 8'h81, 0, -1);
    gap(2, 1'b0);
    run_txn(13'h0F2, 1'b1, 8'h05, 0, -1);
    gap(2, 1'b0);
    run_txn(13'h0F2, 1'b0, 8'h00, 0, -1);
    gap(2, 1'b0);
    run_txn(13'h0F3, 1'b0, 8'h00, 0, -1);
    gap(2, 1'b0);
    run_txn(13'h0F3, 1'b1, 8'h80, 0, -1);
    gap(3, 1'b0);

    // Abort during WAIT leaves gpio_out alone.
    run_txn(13'h0F0, 1'b1, 8'h5A, 1, -1);
    @(negedge clk);
    check("abort_gpio", gpio_out, 8'hA5);
    @(posedge clk); #1;
    gap(3, 1'b1);

    // Randomised traffic.
    for (int n = 0; n < 70; n++) begin
      random_txn();
      gap(3 + $urandom_range(0, 2), 1'($urandom));
    end

    // Reset in the ACK cycle of a write.
    run_txn(13'h0F0, 1'b1, 8'h77, 2, -1);
    gap(3, 1'b1);
    for (int n = 0; n < 15; n++) begin
      random_txn();
      gap(3 + $urandom_range(0, 2), 1'($urandom));
    end

    gap(4, 1'b0);
    check("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule
